// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared encodings and helpers for the EX-stage branch redirect controller.
// Imported by the controller top and its performance counter.
package branch_redirect_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PEND  = 2'd1,
      ST_FLUSH = 2'd2
   } redirect_state_e;

   localparam logic [31:0] JALR_LSB_MASK = 32'hFFFF_FFFE;
   localparam int unsigned FLUSH_CNT_W   = 2;

   // JALR targets have bit 0 cleared; every other transfer keeps its target.
   function automatic logic [31:0] capture_target(input logic [31:0] tgt,
                                                  input logic        jalr);
      logic [31:0] res;
      if (jalr) begin
         res = tgt & JALR_LSB_MASK;
      end else begin
         res = tgt;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_redirect_ctrl_perf_counter.sv
// Enable-increment wrapping event counter used for taken control transfers.
// Wraps from all-ones to zero.
module branch_perf_counter
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // count register, increments once per enabled cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= {WIDTH{1'b0}};
      end else if (en) begin
         count <= count + ONE;
      end
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump redirect controller: captures the taken target, holds it
// across stalls, and drives a registered PC redirect plus front-end flush window.
module branch_redirect_ctrl
   import branch_redirect_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ex_valid,
   input  logic        branch_taken,
   input  logic [31:0] target,
   input  logic        is_jalr,
   input  logic        stall,
   output logic        pc_sel,
   output logic [31:0] redirect_pc,
   output logic        target_misaligned,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        busy,
   output logic [31:0] taken_count
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES);

   redirect_state_e         state_r, state_s;
   logic [FLUSH_CNT_W-1:0]  cnt_r, cnt_s;
   logic                    first_r, first_s;
   logic [31:0]             rpc_s;
   logic                    accept_s;

   // next-state, flush countdown and target capture
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      first_s  = first_r;
      rpc_s    = redirect_pc;
      accept_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (ex_valid && branch_taken) begin
               accept_s = 1'b1;
               rpc_s    = capture_target(target, is_jalr);
               if (stall) begin
                  state_s = ST_PEND;
               end else begin
                  state_s = ST_FLUSH;
                  cnt_s   = FLUSH_LOAD;
                  first_s = 1'b1;
               end
            end else begin
               first_s = 1'b0;
            end
         end
         ST_PEND: begin
            if (!stall) begin
               state_s = ST_FLUSH;
               cnt_s   = FLUSH_LOAD;
               first_s = 1'b1;
            end else begin
               first_s = 1'b0;
            end
         end
         ST_FLUSH: begin
            // a stalled flush cycle is frozen, including the pc_sel pulse
            if (!stall) begin
               first_s = 1'b0;
               if (cnt_r == {{(FLUSH_CNT_W-1){1'b0}}, 1'b1}) begin
                  state_s = ST_IDLE;
               end else begin
                  cnt_s = cnt_r - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
               end
            end else begin
               first_s = first_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            first_s = 1'b0;
         end
      endcase
   end

   // state, counter and registered outputs decoded from the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r           <= ST_IDLE;
         cnt_r             <= {FLUSH_CNT_W{1'b0}};
         first_r           <= 1'b0;
         redirect_pc       <= 32'h0000_0000;
         pc_sel            <= 1'b0;
         target_misaligned <= 1'b0;
         flush_if_id       <= 1'b0;
         flush_id_ex       <= 1'b0;
         busy              <= 1'b0;
      end else begin
         state_r           <= state_s;
         cnt_r             <= cnt_s;
         first_r           <= first_s;
         redirect_pc       <= rpc_s;
         pc_sel            <= first_s;
         target_misaligned <= first_s & rpc_s[1];
         flush_if_id       <= (state_s == ST_FLUSH);
         flush_id_ex       <= (state_s == ST_FLUSH);
         busy              <= (state_s != ST_IDLE);
      end
   end

   branch_perf_counter #(
      .WIDTH (32)
   ) u_taken_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (accept_s),
      .count   (taken_count)
   );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two instances (FLUSH_CYCLES=1 and 2) against a
// behavioural redirect model, plus directed literal checks and a counter wrap check.
module tb_branch_redirect_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ex_valid, branch_taken, is_jalr, stall;
   logic [31:0] target;

   logic        ps1, mis1, fi1, fe1, bz1;
   logic [31:0] rpc1, cnt1;
   logic        ps2, mis2, fi2, fe2, bz2;
   logic [31:0] rpc2, cnt2;

   logic        wc_en;
   logic [3:0]  wc_cnt;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.FLUSH_CYCLES(1)) u1 (
      .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .branch_taken(branch_taken),
      .target(target), .is_jalr(is_jalr), .stall(stall), .pc_sel(ps1),
      .redirect_pc(rpc1), .target_misaligned(mis1), .flush_if_id(fi1),
      .flush_id_ex(fe1), .busy(bz1), .taken_count(cnt1));

   branch_redirect_ctrl #(.FLUSH_CYCLES(2)) u2 (
      .clk(clk), .reset_n(reset_n), .ex_valid(ex_valid), .branch_taken(branch_taken),
      .target(target), .is_jalr(is_jalr), .stall(stall), .pc_sel(ps2),
      .redirect_pc(rpc2), .target_misaligned(mis2), .flush_if_id(fi2),
      .flush_id_ex(fe2), .busy(bz2), .taken_count(cnt2));

   branch_perf_counter #(.WIDTH(4)) u_wc (
      .clk(clk), .reset_n(reset_n), .en(wc_en), .count(wc_cnt));

   // Model: a redirect is either waiting out a stall, or has some flush cycles left.
   typedef struct {
      bit          pend;
      int          left;
      bit          first;
      logic [31:0] rpc;
      logic [31:0] cnt;
   } mdl_t;

   mdl_t m1, m2;

   function automatic mdl_t mstep(mdl_t m, int fc, logic ev, logic bt,
                                  logic [31:0] tg, logic jr, logic st);
      mdl_t n = m;
      if (m.left > 0) begin
         if (!st) begin
            n.left  = m.left - 1;
            n.first = 1'b0;
         end
      end else if (m.pend) begin
         if (!st) begin
            n.pend  = 1'b0;
            n.left  = fc;
            n.first = 1'b1;
         end
      end else if (ev && bt) begin
         n.rpc = jr ? {tg[31:1], 1'b0} : tg;
         n.cnt = m.cnt + 32'd1;
         if (st) n.pend = 1'b1;
         else begin
            n.left  = fc;
            n.first = 1'b1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m1 <= '{default: '0};
         m2 <= '{default: '0};
      end else begin
         m1 <= mstep(m1, 1, ex_valid, branch_taken, target, is_jalr, stall);
         m2 <= mstep(m2, 2, ex_valid, branch_taken, target, is_jalr, stall);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp(input string tag, input mdl_t m, input logic ps, input logic mis,
                      input logic fi, input logic fe, input logic bz,
                      input logic [31:0] rpc, input logic [31:0] cnt);
      chk({tag, ".pc_sel"}, {31'd0, ps}, {31'd0, m.first});
      chk({tag, ".misaligned"}, {31'd0, mis}, {31'd0, m.first & m.rpc[1]});
      chk({tag, ".flush_if_id"}, {31'd0, fi}, {31'd0, (m.left > 0)});
      chk({tag, ".flush_id_ex"}, {31'd0, fe}, {31'd0, (m.left > 0)});
      chk({tag, ".busy"}, {31'd0, bz}, {31'd0, (m.pend || m.left > 0)});
      chk({tag, ".redirect_pc"}, rpc, m.rpc);
      chk({tag, ".taken_count"}, cnt, m.cnt);
   endtask

   // compare both instances against the model every cycle, away from the active edge
   always @(negedge clk) begin
      cmp("u1", m1, ps1, mis1, fi1, fe1, bz1, rpc1, cnt1);
      cmp("u2", m2, ps2, mis2, fi2, fe2, bz2, rpc2, cnt2);
   end

   task automatic step(input logic ev, input logic bt, input logic [31:0] tg,
                       input logic jr, input logic st);
      ex_valid = ev; branch_taken = bt; target = tg; is_jalr = jr; stall = st;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n = 1'b0; wc_en = 1'b0;
      ex_valid = 1'b0; branch_taken = 1'b0; target = 32'h0; is_jalr = 1'b0; stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, bz1}, 32'd0);
      chk("rst_pc_sel", {31'd0, ps1}, 32'd0);
      chk("rst_count", cnt1, 32'd0);
      @(negedge clk); #2 reset_n = 1'b1;

      // taken BEQ, no stall
      step(1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
      chk("beq_pc_sel", {31'd0, ps1}, 32'd1);
      chk("beq_redirect", rpc1, 32'h0000_0100);
      chk("beq_flush", {30'd0, fi1, fe1}, 32'd3);
      chk("beq_count", cnt1, 32'd1);
      idle(1);
      chk("beq_flush_end", {31'd0, fi1}, 32'd0);
      chk("beq_fc2_flush2", {31'd0, fi2}, 32'd1);
      idle(1);

      // JALR with odd target
      step(1'b1, 1'b1, 32'h0000_2003, 1'b1, 1'b0);
      chk("jalr_redirect", rpc1, 32'h0000_2002);
      chk("jalr_misaligned", {31'd0, mis1}, 32'd1);
      chk("jalr_pc_sel", {31'd0, ps1}, 32'd1);
      idle(1);
      chk("jalr_mis_clear", {31'd0, mis1}, 32'd0);
      idle(1);

      // taken while stalled for 3 cycles, target input changes meanwhile
      step(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
      chk("pend_busy", {31'd0, bz1}, 32'd1);
      chk("pend_no_pc_sel", {31'd0, ps1}, 32'd0);
      step(1'b1, 1'b1, 32'hDEAD_BEE0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'h1234_5678, 1'b1, 1'b1);
      chk("pend_no_flush", {31'd0, fi1}, 32'd0);
      step(1'b1, 1'b1, 32'h0000_0500, 1'b0, 1'b0);
      chk("pend_pc_sel", {31'd0, ps1}, 32'd1);
      chk("pend_redirect", rpc1, 32'h0000_0300);
      chk("pend_count", cnt1, 32'd3);
      idle(2);

      // FLUSH_CYCLES=2 with a 2-cycle stall in the second flush cycle
      step(1'b1, 1'b1, 32'h0000_0400, 1'b0, 1'b0);
      chk("fc2_c1_pc_sel", {31'd0, ps2}, 32'd1);
      step(1'b1, 1'b1, 32'h0000_0800, 1'b0, 1'b0);
      chk("fc2_c2_pc_sel", {31'd0, ps2}, 32'd0);
      chk("fc2_c2_flush", {31'd0, fi2}, 32'd1);
      step(1'b1, 1'b1, 32'h0000_0900, 1'b0, 1'b1);
      chk("fc2_c3_flush", {31'd0, fi2}, 32'd1);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      chk("fc2_c4_flush", {31'd0, fe2}, 32'd1);
      chk("fc2_c4_pc_sel", {31'd0, ps2}, 32'd0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("fc2_done_flush", {31'd0, fi2}, 32'd0);
      chk("fc2_done_busy", {31'd0, bz2}, 32'd0);
      chk("fc2_count", cnt2, 32'd4);
      chk("fc2_redirect", rpc2, 32'h0000_0400);
      idle(3);

      // asynchronous reset in the middle of a flush
      step(1'b1, 1'b1, 32'h0000_0600, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      chk("rstmid_flush", {30'd0, fi2, fe2}, 32'd0);
      chk("rstmid_pc_sel", {31'd0, ps2}, 32'd0);
      chk("rstmid_busy", {31'd0, bz2}, 32'd0);
      chk("rstmid_redirect", rpc2, 32'd0);
      chk("rstmid_count", cnt2, 32'd0);
      @(negedge clk); #2 reset_n = 1'b1;
      step(1'b1, 1'b1, 32'h0000_0700, 1'b0, 1'b0);
      chk("rstpost_pc_sel", {31'd0, ps1}, 32'd1);
      chk("rstpost_count", cnt1, 32'd1);
      idle(3);

      // counter wrap on a narrow instance of the same counter
      wc_en = 1'b1;
      repeat (15) @(posedge clk);
      #1;
      chk("wrap_full", {28'd0, wc_cnt}, 32'd15);
      @(posedge clk);
      #1;
      chk("wrap_zero", {28'd0, wc_cnt}, 32'd0);
      wc_en = 1'b0;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
